// File: rtl/hazard_scoreboard_pkg.sv
// Shared defaults, counter-width derivation and index type for the hazard scoreboard.
// HAZARD_FWD_EN (optional define) enables the bypass-aware variant.
package hazard_scoreboard_pkg;

    localparam int NUM_REGS_DFLT = 32;
    localparam int ADDR_W_DFLT   = $clog2(NUM_REGS_DFLT);
    localparam int WB_DEPTH_DFLT = 2;

    // A select of 0 always means "read the register file".
    localparam int FSEL_REGFILE = 0;

    typedef logic [ADDR_W_DFLT-1:0] reg_idx_t;

    function automatic int cntWidth(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_entry.sv
// One register's countdown state: cycles until writeback and, with HAZARD_FWD_EN,
// cycles until the value is on the bypass network.
module hazard_sb_entry
    import hazard_scoreboard_pkg::*;
#(
    parameter int WB_DEPTH = WB_DEPTH_DFLT,
    parameter int CNT_W    = cntWidth(WB_DEPTH)
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
`ifdef HAZARD_FWD_EN
    input  logic [CNT_W-1:0] fwd_lat,
    output logic [CNT_W-1:0] fw_cnt,
`endif
    output logic [CNT_W-1:0] wb_cnt
);

    logic [CNT_W-1:0] wbCnt_q, wbCnt_d;

    // A new writer reloads the counter even if an older write is still pending.
    always_comb begin
        wbCnt_d = (wbCnt_q != '0) ? wbCnt_q - CNT_W'(1) : '0;
        if (load)
            wbCnt_d = CNT_W'(WB_DEPTH);
    end

    always_ff @(posedge clk) begin
        if (rst)
            wbCnt_q <= '0;
        else
            wbCnt_q <= wbCnt_d;
    end

    assign wb_cnt = wbCnt_q;

`ifdef HAZARD_FWD_EN
    logic [CNT_W-1:0] fwCnt_q, fwCnt_d;

    // Bypass latency cannot exceed the writeback distance.
    always_comb begin
        fwCnt_d = (fwCnt_q != '0) ? fwCnt_q - CNT_W'(1) : '0;
        if (load)
            fwCnt_d = (fwd_lat > CNT_W'(WB_DEPTH)) ? CNT_W'(WB_DEPTH) : fwd_lat;
    end

    always_ff @(posedge clk) begin
        if (rst)
            fwCnt_q <= '0;
        else
            fwCnt_q <= fwCnt_d;
    end

    assign fw_cnt = fwCnt_q;
`endif

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard: per-register countdowns drive PC/IF-ID stalls, ID/EX bubbles
// and, with HAZARD_FWD_EN defined, bypass-mux selects.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DFLT,
    parameter int ADDR_W   = ADDR_W_DFLT,
    parameter int WB_DEPTH = WB_DEPTH_DFLT,
    parameter int CNT_W    = cntWidth(WB_DEPTH)
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs1,
    input  logic [ADDR_W-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic [CNT_W-1:0]  id_fwd_lat,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              bubble_sel,
    output logic [CNT_W-1:0]  fwd_sel_rs1,
    output logic [CNT_W-1:0]  fwd_sel_rs2,
    output logic [31:0]       stall_count
);

    logic [CNT_W-1:0] wbCnt [NUM_REGS];
    logic             rs1Busy, rs2Busy, stall, issue;
    logic [31:0]      stallCount_q, stallCount_d;

    assign wbCnt[0] = '0;

`ifdef HAZARD_FWD_EN
    logic [CNT_W-1:0] fwCnt [NUM_REGS];
    assign fwCnt[0] = '0;
`else
    logic unusedFwdLat;
    assign unusedFwdLat = ^id_fwd_lat;
`endif

    // x0 has no entry; lookups of it always read zero.
    for (genvar r = 1; r < NUM_REGS; r++) begin : gEntry
        hazard_sb_entry #(
            .WB_DEPTH (WB_DEPTH),
            .CNT_W    (CNT_W)
        ) uEntry (
            .clk     (clk),
            .rst     (rst),
            .load    (issue && (id_rd == ADDR_W'(r))),
`ifdef HAZARD_FWD_EN
            .fwd_lat (id_fwd_lat),
            .fw_cnt  (fwCnt[r]),
`endif
            .wb_cnt  (wbCnt[r])
        );
    end

    // Sources see the counters before this instruction's own write lands.
    always_comb begin
`ifdef HAZARD_FWD_EN
        rs1Busy = (id_rs1 != '0) && (fwCnt[id_rs1] != '0);
        rs2Busy = (id_rs2 != '0) && (fwCnt[id_rs2] != '0);
`else
        rs1Busy = (id_rs1 != '0) && (wbCnt[id_rs1] != '0);
        rs2Busy = (id_rs2 != '0) && (wbCnt[id_rs2] != '0);
`endif
        stall = id_valid && ((id_use_rs1 && rs1Busy) || (id_use_rs2 && rs2Busy));
        issue = id_valid && !stall && id_regwrite && (id_rd != '0);
    end

    assign pc_en      = ~stall;
    assign if_id_en   = ~stall;
    assign bubble_sel = stall;

`ifdef HAZARD_FWD_EN
    // Bypass only once the producer's result exists and before it reaches the regfile.
    always_comb begin
        fwd_sel_rs1 = CNT_W'(FSEL_REGFILE);
        fwd_sel_rs2 = CNT_W'(FSEL_REGFILE);
        if ((id_rs1 != '0) && id_use_rs1 && (fwCnt[id_rs1] == '0) && (wbCnt[id_rs1] != '0))
            fwd_sel_rs1 = wbCnt[id_rs1];
        if ((id_rs2 != '0) && id_use_rs2 && (fwCnt[id_rs2] == '0) && (wbCnt[id_rs2] != '0))
            fwd_sel_rs2 = wbCnt[id_rs2];
    end
`else
    assign fwd_sel_rs1 = CNT_W'(FSEL_REGFILE);
    assign fwd_sel_rs2 = CNT_W'(FSEL_REGFILE);
`endif

    always_comb begin
        stallCount_d = stallCount_q;
        if (stall && (stallCount_q != 32'hFFFF_FFFF))
            stallCount_d = stallCount_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            stallCount_q <= '0;
        else
            stallCount_q <= stallCount_d;
    end

    assign stall_count = stallCount_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard; table vectors plus a reset sequence.
// Expectations switch with HAZARD_FWD_EN to match the build.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int CW = cntWidth(WB_DEPTH_DFLT);

    typedef struct {
        logic          valid;
        reg_idx_t      rs1;
        reg_idx_t      rs2;
        logic          use1;
        logic          use2;
        reg_idx_t      rd;
        logic          rw;
        logic [CW-1:0] lat;
        logic          expStall;
        logic [CW-1:0] expSel1;
        logic [CW-1:0] expSel2;
    } vec_t;

    typedef struct {
        logic          stall;
        logic [CW-1:0] sel1;
        logic [CW-1:0] sel2;
        logic [31:0]   cnt;
        string         name;
    } exp_t;

    logic          clk, rst;
    logic          id_valid, id_use_rs1, id_use_rs2, id_regwrite;
    reg_idx_t      id_rs1, id_rs2, id_rd;
    logic [CW-1:0] id_fwd_lat;
    logic          pc_en, if_id_en, bubble_sel;
    logic [CW-1:0] fwd_sel_rs1, fwd_sel_rs2;
    logic [31:0]   stall_count;

    int   errors = 0;
    int   checks = 0;
    int   expStallCount = 0;
    exp_t sbQ[$];
    vec_t tbl[$];

    hazard_scoreboard dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_fwd_lat  (id_fwd_lat),
        .pc_en       (pc_en),
        .if_id_en    (if_id_en),
        .bubble_sel  (bubble_sel),
        .fwd_sel_rs1 (fwd_sel_rs1),
        .fwd_sel_rs2 (fwd_sel_rs2),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input int v, input int r1, input int r2, input int u1, input int u2,
                                input int rd, input int rw, input int lat,
                                input int st, input int s1, input int s2);
        vec_t x;
        x.valid    = v[0];
        x.rs1      = reg_idx_t'(r1);
        x.rs2      = reg_idx_t'(r2);
        x.use1     = u1[0];
        x.use2     = u2[0];
        x.rd       = reg_idx_t'(rd);
        x.rw       = rw[0];
        x.lat      = CW'(lat);
        x.expStall = st[0];
        x.expSel1  = CW'(s1);
        x.expSel2  = CW'(s2);
        return x;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic driveIdle();
        id_valid    = 1'b0;
        id_rs1      = '0;
        id_rs2      = '0;
        id_use_rs1  = 1'b0;
        id_use_rs2  = 1'b0;
        id_rd       = '0;
        id_regwrite = 1'b0;
        id_fwd_lat  = '0;
    endtask

    // Drive one ID-stage instruction just after the edge and queue what it must produce.
    task automatic applyStimulus(input vec_t v, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        id_valid    = v.valid;
        id_rs1      = v.rs1;
        id_rs2      = v.rs2;
        id_use_rs1  = v.use1;
        id_use_rs2  = v.use2;
        id_rd       = v.rd;
        id_regwrite = v.rw;
        id_fwd_lat  = v.lat;
        e.stall = v.expStall;
        e.sel1  = v.expSel1;
        e.sel2  = v.expSel2;
        e.cnt   = 32'(expStallCount);
        e.name  = name;
        sbQ.push_back(e);
        if (v.expStall)
            expStallCount++;
    endtask

    task automatic checkOutput();
        exp_t e;
        @(negedge clk);
        if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
            return;
        end
        e = sbQ.pop_front();
        checkVal({e.name, ".pc_en"},       32'(pc_en),       32'(!e.stall));
        checkVal({e.name, ".if_id_en"},    32'(if_id_en),    32'(!e.stall));
        checkVal({e.name, ".bubble_sel"},  32'(bubble_sel),  32'(e.stall));
        checkVal({e.name, ".fwd_sel_rs1"}, 32'(fwd_sel_rs1), 32'(e.sel1));
        checkVal({e.name, ".fwd_sel_rs2"}, 32'(fwd_sel_rs2), 32'(e.sel2));
        checkVal({e.name, ".stall_count"}, 32'(stall_count), e.cnt);
    endtask

    task automatic runVec(input vec_t v, input string name);
        applyStimulus(v, name);
        checkOutput();
    endtask

    initial begin
        rst = 1'b1;
        driveIdle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`ifdef HAZARD_FWD_EN
        tbl.push_back(mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 2, 0));
        tbl.push_back(mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 7, 0, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 7, 0, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 8, 1, 3, 0, 0, 0));
        tbl.push_back(mk(1, 8, 0, 1, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 8, 0, 1, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 8, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 13, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 13, 13, 0, 1, 0, 0, 0, 0, 0, 2));
`else
        tbl.push_back(mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 5, 0, 1, 0, 6, 1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 5, 0, 1, 0, 6, 1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 5, 0, 1, 0, 6, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 9, 0, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 9, 0, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 9, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 3, 0, 1, 0, 4, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3, 0, 1, 0, 12, 1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 3, 4, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 12, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 10, 0, 1, 0, 10, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 10, 0, 1, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 10, 0, 1, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 10, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 11, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 11, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 11, 0, 1, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 11, 0, 1, 0, 0, 0, 0, 0, 0, 0));
`endif

        for (int i = 0; i < tbl.size(); i++)
            runVec(tbl[i], $sformatf("tbl[%0d]", i));

        // Pending write to x5 is discarded by a one-cycle reset.
        runVec(mk(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0), "rstIssue");
        @(posedge clk);
        #1;
        rst = 1'b1;
        driveIdle();
        expStallCount = 0;
        runVec(mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0), "rstDependent");

        checkVal("queueDrained", 32'(sbQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
